nn_host_loader: RTL and testbench

// Host-side initiator for the accelerator's memory-mapped slave port (write/read/available).

---
 rtl/nn_host_loader_if.sv | 42 ++++
 rtl/nn_host_loader.sv | 203 ++++++++++++++++++++
 tb/tb_nn_host_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_host_loader_if.sv
// Host command/response streams plus the accelerator's memory-mapped bus, bundled for nn_host_loader.
// The master modport is the loader's view; the slave modport is the host link plus accelerator.
interface nn_host_loader_if #(
  parameter int MM_DEPTH = 16,
  parameter int MM_WIDTH = 32,
  parameter int Q_DEPTH  = 16,
  parameter int CNT_W    = 8
);
  // Both streams: a word moves on a rising edge where valid & ready are high; valid never
  // waits on ready, and payload holds steady while valid is high and ready is low.
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [MM_DEPTH-1:0] cmd_addr;
  logic [MM_WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0]    cmd_count;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [Q_DEPTH-1:0]  rsp_data;
  logic                rsp_last;

  logic                write_enable;
  logic [MM_DEPTH-1:0] write_addr;
  logic [MM_WIDTH-1:0] write_data;
  logic                read_enable;
  logic [MM_DEPTH-1:0] read_addr;
  logic [Q_DEPTH-1:0]  read_data;
  logic                available;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_count, rsp_ready, read_data, available,
    output cmd_ready, rsp_valid, rsp_data, rsp_last,
           write_enable, write_addr, write_data, read_enable, read_addr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_count, rsp_ready, read_data, available,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last,
           write_enable, write_addr, write_data, read_enable, read_addr
  );
endinterface

// File: rtl/nn_host_loader.sv
// Turns host WRITE/RUN/READ commands into accelerator bus cycles; READ results return
// through a small first-word-fall-through buffer with credit-based read issue.
module nn_host_loader #(
  parameter int                  MM_DEPTH    = 16,
  parameter int                  MM_WIDTH    = 32,
  parameter int                  Q_DEPTH     = 16,
  parameter int                  CNT_W       = 8,
  parameter int                  FIFO_DEPTH  = 4,
  parameter logic [MM_DEPTH-1:0] STATUS_ADDR = 16'hF000,
  parameter logic [MM_WIDTH-1:0] RUN_WORD    = 32'h1,
  parameter int                  TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  nn_host_loader_if.master io,
  output logic             busy,
  output logic             error,
  output logic [2:0]       state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RUN_WR, S_WAIT_START, S_WAIT_DONE, S_READ, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                live_q, live_d;
  logic                error_q, error_d;
  logic                we_q, we_d;
  logic [MM_DEPTH-1:0] waddr_q, waddr_d;
  logic [MM_WIDTH-1:0] wdata_q, wdata_d;
  logic                re_q, re_d;
  logic [MM_DEPTH-1:0] raddr_q, raddr_d;
  logic                rlast_q, rlast_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pend_q, pend_d;
  logic                pend_last_q, pend_last_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [Q_DEPTH:0]    mem_q [FIFO_DEPTH];

  logic                fifo_empty, push, pop, cmd_ready, accept, credit_ok;
  logic [AW+1:0]       occupancy;
  logic [Q_DEPTH:0]    head;

  assign fifo_empty = (count_q == '0);
  assign push       = pend_q;
  assign pop        = !fifo_empty && io.rsp_ready;
  // Words already in the buffer plus reads whose data has not landed yet.
  assign occupancy  = (AW+2)'(count_q) + (AW+2)'(re_q) + (AW+2)'(pend_q);
  assign credit_ok  = occupancy < (AW+2)'(FIFO_DEPTH);
  assign cmd_ready  = live_q && (state_q == S_IDLE) && io.available && fifo_empty;
  assign accept     = cmd_ready && io.cmd_valid;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    live_d      = 1'b1;
    error_d     = error_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    re_d        = 1'b0;
    raddr_d     = raddr_q;
    rlast_d     = 1'b0;
    remain_d    = remain_q;
    timer_d     = timer_q;
    pend_d      = re_q;
    pend_last_d = rlast_q;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (io.cmd_op)
            2'b00: begin
              we_d    = 1'b1;
              waddr_d = io.cmd_addr;
              wdata_d = io.cmd_data;
              state_d = S_WRITE;
            end
            2'b01: begin
              we_d    = 1'b1;
              waddr_d = STATUS_ADDR;
              wdata_d = RUN_WORD;
              state_d = S_RUN_WR;
            end
            2'b10: begin
              // First read issues on the accept edge to hit the 3-cycle response latency.
              re_d     = 1'b1;
              raddr_d  = io.cmd_addr;
              remain_d = io.cmd_count;
              rlast_d  = (io.cmd_count == '0);
              state_d  = (io.cmd_count == '0) ? S_DRAIN : S_READ;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RUN_WR: begin
        state_d = S_WAIT_START;
        timer_d = TW'(TIMEOUT);
      end
      S_WAIT_START: begin
        if (!io.available) begin
          state_d = S_WAIT_DONE;
          timer_d = TW'(TIMEOUT);
        end else if (timer_q <= TW'(1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (io.available) begin
          state_d = S_IDLE;
        end else if (timer_q <= TW'(1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_READ: begin
        if (credit_ok) begin
          re_d     = 1'b1;
          raddr_d  = raddr_q + MM_DEPTH'(1);
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            rlast_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !re_q && !pend_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      error_q     <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      re_q        <= 1'b0;
      raddr_q     <= '0;
      rlast_q     <= 1'b0;
      remain_q    <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      error_q     <= error_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      re_q        <= re_d;
      raddr_q     <= raddr_d;
      rlast_q     <= rlast_d;
      remain_q    <= remain_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it while the count is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pend_last_q, io.read_data};
  end

  assign io.cmd_ready    = cmd_ready;
  assign io.rsp_valid    = !fifo_empty;
  assign io.rsp_data     = fifo_empty ? '0 : head[Q_DEPTH-1:0];
  assign io.rsp_last     = !fifo_empty && head[Q_DEPTH];
  assign io.write_enable = we_q;
  assign io.write_addr   = waddr_q;
  assign io.write_data   = wdata_q;
  assign io.read_enable  = re_q;
  assign io.read_addr    = raddr_q;
  assign busy            = (state_q != S_IDLE);
  assign error           = error_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_nn_host_loader.sv
// Directed bench for nn_host_loader: write, run handshake, timeout, reserved op,
// streaming and back-pressured reads, address wrap and reset mid-burst.
module tb_nn_host_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nn_host_loader_if bi ();
  nn_host_loader_if ti ();
  logic       busy, error, busy_t, error_t;
  logic [2:0] st, st_t;

  nn_host_loader dut (
    .clk(clk), .reset(reset), .io(bi), .busy(busy), .error(error), .state_dbg(st)
  );
  nn_host_loader #(.TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .io(ti), .busy(busy_t), .error(error_t), .state_dbg(st_t)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt_t = 0;
  logic [15:0] addr_log[$];

  // Accelerator bus model: synchronous memory returning addr+100 one cycle after the strobe.
  always @(posedge clk) begin
    if (bi.write_enable) wr_cnt++;
    if (ti.write_enable) wr_cnt_t++;
    if (bi.read_enable) begin
      rd_cnt++;
      addr_log.push_back(bi.read_addr);
      bi.read_data <= bi.read_addr + 16'd100;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] addr,
                      input logic [31:0] data, input logic [7:0] cnt);
    int w = 0;
    bi.cmd_op = op; bi.cmd_addr = addr; bi.cmd_data = data; bi.cmd_count = cnt;
    bi.cmd_valid = 1'b1;
    while (!bi.cmd_ready && w < 100) begin cyc(); w++; end
    n_cmp++;
    if (bi.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL cmd_accept: ready=%b after %0d cycles, want 1", bi.cmd_ready, w);
    end
    cyc();
    bi.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < 200) begin cyc(); w++; end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, w);
    end
  endtask

  task automatic test_reset();
    cyc();
    n_cmp++;
    if ({bi.cmd_ready, bi.rsp_valid, bi.rsp_last, bi.rsp_data, busy, error, bi.write_enable,
         bi.write_addr, bi.write_data, bi.read_enable, bi.read_addr} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: rdy=%b rv=%b we=%b re=%b busy=%b err=%b, want all 0",
                        bi.cmd_ready, bi.rsp_valid, bi.write_enable, bi.read_enable, busy, error);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if (bi.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", bi.cmd_ready);
    end
  endtask

  task automatic test_write();
    wr_cnt = 0;
    send(2'b00, 16'h0012, 32'h0000ABCD, 8'd0);
    n_cmp++;
    if ({bi.write_enable, bi.write_addr, bi.write_data} !== {1'b1, 16'h0012, 32'h0000ABCD}) begin
      n_bad++; $display("FAIL write_strobe: we=%b addr=%h data=%h want 1/0012/0000abcd",
                        bi.write_enable, bi.write_addr, bi.write_data);
    end
    cyc();
    n_cmp++;
    if ({bi.write_enable, bi.cmd_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL write_after: we/rdy/busy=%b want 010",
                        {bi.write_enable, bi.cmd_ready, busy});
    end
    n_cmp++;
    if (wr_cnt !== 1) begin
      n_bad++; $display("FAIL write_count: got %0d want 1", wr_cnt);
    end
  endtask

  task automatic test_run();
    int bad_busy = 0;
    wr_cnt = 0;
    bi.available = 1'b1;
    send(2'b01, 16'h0, 32'h0, 8'd0);
    n_cmp++;
    if ({bi.write_enable, bi.write_addr, bi.write_data} !== {1'b1, 16'hF000, 32'h1}) begin
      n_bad++; $display("FAIL run_strobe: we=%b addr=%h data=%h want 1/f000/00000001",
                        bi.write_enable, bi.write_addr, bi.write_data);
    end
    repeat (3) begin
      if (busy !== 1'b1) bad_busy++;
      cyc();
    end
    bi.available = 1'b0;
    repeat (20) begin
      if (busy !== 1'b1) bad_busy++;
      cyc();
    end
    if (busy !== 1'b1) bad_busy++;
    bi.available = 1'b1;
    cyc();
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++; $display("FAIL run_busy_window: %0d low cycles, want 0", bad_busy);
    end
    n_cmp++;
    if ({busy, st} !== {1'b0, 3'd0}) begin
      n_bad++; $display("FAIL run_idle: busy=%b state=%0d want 0/0", busy, st);
    end
    n_cmp++;
    if ({error, 32'(wr_cnt)} !== {1'b0, 32'd1}) begin
      n_bad++; $display("FAIL run_err_writes: err=%b writes=%0d want 0/1", error, wr_cnt);
    end
  endtask

  task automatic test_timeout();
    int waitc = 0;
    n_cmp++;
    if (ti.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL to_ready: got %b want 1", ti.cmd_ready);
    end
    ti.cmd_op = 2'b01; ti.cmd_valid = 1'b1;
    cyc();
    ti.cmd_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (st_t == 3'd3) waitc++;
      if (st_t == 3'd0) break;
    end
    n_cmp++;
    if (waitc !== 16) begin
      n_bad++; $display("FAIL to_wait_cycles: got %0d want 16", waitc);
    end
    n_cmp++;
    if ({error_t, busy_t} !== 2'b10) begin
      n_bad++; $display("FAIL to_error: err/busy=%b want 10", {error_t, busy_t});
    end
    wr_cnt_t = 0;
    ti.cmd_op = 2'b00; ti.cmd_addr = 16'h0005; ti.cmd_data = 32'h77; ti.cmd_valid = 1'b1;
    n_cmp++;
    if (ti.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL to_ready_after: got %b want 1", ti.cmd_ready);
    end
    cyc();
    ti.cmd_valid = 1'b0;
    n_cmp++;
    if ({ti.write_enable, ti.write_addr, error_t} !== {1'b1, 16'h0005, 1'b1}) begin
      n_bad++; $display("FAIL to_write_after: we=%b addr=%h err=%b want 1/0005/1",
                        ti.write_enable, ti.write_addr, error_t);
    end
  endtask

  task automatic test_reserved();
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++; $display("FAIL rsv_pre_error: got %b want 0", error);
    end
    send(2'b11, 16'h0, 32'h0, 8'd0);
    n_cmp++;
    if ({error, busy, bi.cmd_ready, bi.write_enable, bi.read_enable} !== 5'b10100) begin
      n_bad++; $display("FAIL rsv_error: err/busy/rdy/we/re=%b want 10100",
                        {error, busy, bi.cmd_ready, bi.write_enable, bi.read_enable});
    end
  endtask

  task automatic test_read_stream();
    int first = -1;
    bi.rsp_ready = 1'b1;
    rd_cnt = 0;
    send(2'b10, 16'h0000, 32'h0, 8'd7);
    for (int i = 1; i <= 20; i++) begin
      if (bi.rsp_valid) begin first = i; break; end
      cyc();
    end
    n_cmp++;
    if (first !== 3) begin
      n_bad++; $display("FAIL rd_latency: first valid at %0d want 3", first);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({bi.rsp_valid, bi.rsp_last, bi.rsp_data} !== {1'b1, (k == 7), 16'(100 + k)}) begin
        n_bad++; $display("FAIL rd_word%0d: v=%b last=%b data=%0d want 1/%b/%0d",
                          k, bi.rsp_valid, bi.rsp_last, bi.rsp_data, (k == 7), 100 + k);
      end
      cyc();
    end
    n_cmp++;
    if (bi.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_extra: rsp_valid=%b want 0", bi.rsp_valid);
    end
    wait_idle("rd");
    n_cmp++;
    if (rd_cnt !== 8) begin
      n_bad++; $display("FAIL rd_strobes: got %0d want 8", rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    logic [16:0] e;
    bi.rsp_ready = 1'b0;
    rd_cnt = 0;
    send(2'b10, 16'h0000, 32'h0, 8'd7);
    repeat (10) cyc();
    n_cmp++;
    if (rd_cnt !== 4) begin
      n_bad++; $display("FAIL bp_stall_issues: got %0d want 4", rd_cnt);
    end
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), 16'(100 + k)});
    bi.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      if (bi.rsp_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bi.rsp_last, bi.rsp_data} !== e) begin
          n_bad++; $display("FAIL bp_word: last=%b data=%0d want %b/%0d",
                            bi.rsp_last, bi.rsp_data, e[16], e[15:0]);
        end
      end
      cyc();
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL bp_missing: %0d words undelivered want 0", exp_q.size());
    end
    wait_idle("bp");
    n_cmp++;
    if (rd_cnt !== 8) begin
      n_bad++; $display("FAIL bp_strobes: got %0d want 8", rd_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a[4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bi.rsp_ready = 1'b1;
    addr_log.delete();
    send(2'b10, 16'hFFFE, 32'h0, 8'd3);
    wait_idle("wrap");
    n_cmp++;
    if (addr_log.size() !== 4) begin
      n_bad++; $display("FAIL wrap_count: got %0d want 4", addr_log.size());
    end
    for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
      n_cmp++;
      if (addr_log[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", k, addr_log[k], exp_a[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    bi.rsp_ready = 1'b0;
    send(2'b10, 16'hFFFE, 32'h0, 8'd7);
    repeat (3) cyc();
    n_cmp++;
    if (bi.rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_pending: rsp_valid=%b want 1", bi.rsp_valid);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bi.cmd_ready, bi.rsp_valid, bi.rsp_last, bi.rsp_data, busy, error, bi.write_enable,
         bi.write_addr, bi.write_data, bi.read_enable, bi.read_addr} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: rdy=%b rv=%b data=%h re=%b raddr=%h busy=%b, want all 0",
                        bi.cmd_ready, bi.rsp_valid, bi.rsp_data, bi.read_enable, bi.read_addr, busy);
    end
    repeat (2) cyc();
    reset = 1'b1;
    bi.rsp_ready = 1'b1;
    rd_cnt = 0;
    repeat (10) begin
      cyc();
      if (bi.rsp_valid) stale++;
    end
    n_cmp++;
    if ({32'(stale), 32'(rd_cnt)} !== 64'd0) begin
      n_bad++; $display("FAIL mid_stale: rsp cycles=%0d reads=%0d want 0/0", stale, rd_cnt);
    end
    n_cmp++;
    if ({bi.cmd_ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL mid_recover: rdy/busy=%b want 10", {bi.cmd_ready, busy});
    end
  endtask

  initial begin
    bi.cmd_valid = 1'b0; bi.cmd_op = 2'b00; bi.cmd_addr = '0; bi.cmd_data = '0; bi.cmd_count = '0;
    bi.rsp_ready = 1'b0; bi.read_data = '0; bi.available = 1'b1;
    ti.cmd_valid = 1'b0; ti.cmd_op = 2'b00; ti.cmd_addr = '0; ti.cmd_data = '0; ti.cmd_count = '0;
    ti.rsp_ready = 1'b1; ti.read_data = '0; ti.available = 1'b1;
    repeat (2) cyc();
    test_reset();
    test_write();
    test_run();
    test_timeout();
    test_read_stream();
    test_back_to_back();
    test_wrap();
    test_reserved();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
